player_ctrl: RTL and testbench

Sequential player controller for the Space Invaders datapath. Once per video frame it reads the keyboard keycodes, moves the cannon horizontally, and clamps it to the playfield. It also issues a fire request to the bullet logic and manages the death/respawn period. Its PlayerX/PlayerY/Size outputs feed the combinational player-sprite shape decoder directly; PlayerVisible gates that decoder's output in the colour mapper.

---
 rtl/player_ctrl.sv | 173 +++++++++++++++++
 tb/tb_player_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_ctrl.sv
// Space Invaders player controller: per-frame cannon motion, fire handshake and respawn.
// Optional feature macro: PLAYER_ACCEL_EN (run-length dependent step size).
`timescale 1ns/1ps
module player_ctrl #(
    parameter int unsigned X_START        = 320,
    parameter int unsigned X_MIN          = 12,
    parameter int unsigned X_MAX          = 627,
    parameter int unsigned Y_POS          = 460,
    parameter int unsigned SIZE           = 4,
    parameter int unsigned STEP           = 2,
    parameter int unsigned COOLDOWN       = 20,
    parameter int unsigned RESPAWN_FRAMES = 90
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] Keycode0,
    input  logic [7:0] Keycode1,
    input  logic       PlayerHit,
    input  logic       FireAck,
    output logic [9:0] PlayerX,
    output logic [9:0] PlayerY,
    output logic [4:0] Size,
    output logic       PlayerVisible,
    output logic       FireReq,
    output logic [9:0] FireX
);
    localparam logic [10:0] XMin11  = 11'(X_MIN);
    localparam logic [10:0] XMax11  = 11'(X_MAX);
    localparam logic [9:0]  XMin    = 10'(X_MIN);
    localparam logic [9:0]  XMax    = 10'(X_MAX);
    localparam logic [9:0]  XStart  = 10'(X_START);

    typedef enum logic [1:0] {StIdle, StLeft, StRight, StDead} state_e;

    state_e      r_state, w_state_next;
    logic        r_fsync1, r_fsync2, r_fsync3;
    logic        w_tick;
    logic        w_left, w_right, w_fire, w_mv_left, w_mv_right;
    logic        w_live, w_hit;
    logic [6:0]  r_resp;
    logic [9:0]  r_x;
    logic [4:0]  r_cool;
    logic        r_fire_req;
    logic [9:0]  r_fire_x;
    logic [3:0]  w_step;
    logic [10:0] w_step11;
    logic [9:0]  w_x_dec, w_x_inc;

    // frame_clk is asynchronous: two sync flops plus one for edge detection
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fsync1 <= 1'b0;
            r_fsync2 <= 1'b0;
            r_fsync3 <= 1'b0;
        end else begin
            r_fsync1 <= frame_clk;
            r_fsync2 <= r_fsync1;
            r_fsync3 <= r_fsync2;
        end
    end

    assign w_tick     = r_fsync2 & ~r_fsync3;
    assign w_left     = (Keycode0 == 8'h04) || (Keycode1 == 8'h04);
    assign w_right    = (Keycode0 == 8'h07) || (Keycode1 == 8'h07);
    assign w_fire     = (Keycode0 == 8'h2C) || (Keycode1 == 8'h2C);
    assign w_mv_left  = w_left & ~w_right;
    assign w_mv_right = w_right & ~w_left;
    assign w_live     = (r_state != StDead);
    assign w_hit      = PlayerHit & w_live;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= StIdle;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StDead: begin
                if (w_tick && r_resp == 7'd1) w_state_next = StIdle;
            end
            StIdle, StLeft, StRight: begin
                if (PlayerHit)       w_state_next = StDead;
                else if (w_tick) begin
                    if (w_mv_left)       w_state_next = StLeft;
                    else if (w_mv_right) w_state_next = StRight;
                    else                 w_state_next = StIdle;
                end
            end
        endcase
    end

    always_comb begin
        PlayerX       = r_x;
        PlayerY       = 10'(Y_POS);
        Size          = 5'(SIZE);
        PlayerVisible = (r_state != StDead);
        FireReq       = r_fire_req;
        FireX         = r_fire_x;
    end

`ifdef PLAYER_ACCEL_EN
    logic [4:0] r_run, w_run_next;

    // Run length counts consecutive ticks in one direction, saturating at 17
    always_comb begin
        w_run_next = r_run;
        if (w_hit) begin
            w_run_next = 5'd0;
        end else if (w_live && w_tick) begin
            if ((w_mv_left && r_state == StLeft) || (w_mv_right && r_state == StRight))
                w_run_next = (r_run >= 5'd17) ? 5'd17 : r_run + 5'd1;
            else if (w_mv_left || w_mv_right)
                w_run_next = 5'd1;
            else
                w_run_next = 5'd0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_run <= 5'd0;
        else          r_run <= w_run_next;
    end

    assign w_step = (w_run_next <= 5'd8) ? 4'd1 : (w_run_next <= 5'd16) ? 4'd2 : 4'd4;
`else
    assign w_step = 4'(STEP);
`endif

    // Clamp compares are widened to 11 bits so the position never wraps
    assign w_step11 = {7'd0, w_step};
    assign w_x_dec  = ({1'b0, r_x} < XMin11 + w_step11) ? XMin : r_x - {6'd0, w_step};
    assign w_x_inc  = ({1'b0, r_x} + w_step11 > XMax11) ? XMax : r_x + {6'd0, w_step};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x    <= XStart;
            r_resp <= 7'd0;
        end else if (r_state == StDead) begin
            if (w_tick && r_resp != 7'd0) begin
                r_resp <= r_resp - 7'd1;
                if (r_resp == 7'd1) r_x <= XStart;
            end
        end else if (w_hit) begin
            r_resp <= 7'(RESPAWN_FRAMES);
        end else if (w_tick) begin
            if (w_mv_left)       r_x <= w_x_dec;
            else if (w_mv_right) r_x <= w_x_inc;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cool     <= 5'd0;
            r_fire_req <= 1'b0;
            r_fire_x   <= 10'd0;
        end else begin
            if (w_tick && r_cool != 5'd0) r_cool <= r_cool - 5'd1;
            if (r_fire_req && w_hit) begin
                r_fire_req <= 1'b0;
            end else if (r_fire_req && FireAck) begin
                r_fire_req <= 1'b0;
                r_cool     <= 5'(COOLDOWN);
            end else if (w_tick && w_live && !w_hit && w_fire && r_cool == 5'd0
                         && !r_fire_req) begin
                r_fire_req <= 1'b1;
                r_fire_x   <= r_x;
            end
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: frame-level reference model, status and fire queues.
`timescale 1ns/1ps
module tb_player_ctrl;
    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] Keycode0 = 8'h00;
    logic [7:0] Keycode1 = 8'h00;
    logic       PlayerHit = 1'b0;
    logic       FireAck = 1'b0;
    logic [9:0] PlayerX, PlayerY, FireX;
    logic [4:0] Size;
    logic       PlayerVisible, FireReq;

    player_ctrl dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_clk     (frame_clk),
        .Keycode0      (Keycode0),
        .Keycode1      (Keycode1),
        .PlayerHit     (PlayerHit),
        .FireAck       (FireAck),
        .PlayerX       (PlayerX),
        .PlayerY       (PlayerY),
        .Size          (Size),
        .PlayerVisible (PlayerVisible),
        .FireReq       (FireReq),
        .FireX         (FireX)
    );

    always #10 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int x;
        int vis;
        int req;
        int fx;
    } st_t;
    st_t sq[$];
    int  fq[$];

    // Reference model state, advanced one frame / one event at a time
    int mx, mvis, mreq, mfx, mcool, mresp, mrun, mdir;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mx = 320; mvis = 1; mreq = 0; mfx = 0; mcool = 0; mresp = 0; mrun = 0; mdir = 0;
    endtask

    task automatic model_tick();
        bit l, r, f;
        int dir, step;
        l = (Keycode0 == 8'h04) || (Keycode1 == 8'h04);
        r = (Keycode0 == 8'h07) || (Keycode1 == 8'h07);
        f = (Keycode0 == 8'h2C) || (Keycode1 == 8'h2C);
        if (mvis == 0) begin
            mresp = mresp - 1;
            if (mresp == 0) begin
                mvis = 1; mx = 320; mdir = 0; mrun = 0;
            end
            if (mcool > 0) mcool = mcool - 1;
        end else begin
            if (f && mcool == 0 && mreq == 0) begin
                mreq = 1; mfx = mx; fq.push_back(mx);
            end
            if (mcool > 0) mcool = mcool - 1;
            dir = (l && !r) ? -1 : (r && !l) ? 1 : 0;
            if (dir == 0) begin
                mrun = 0;
            end else begin
                mrun = (dir == mdir) ? ((mrun < 17) ? mrun + 1 : 17) : 1;
`ifdef PLAYER_ACCEL_EN
                step = (mrun <= 8) ? 1 : (mrun <= 16) ? 2 : 4;
`else
                step = 2;
`endif
                mx = mx + dir * step;
                if (mx < 12)  mx = 12;
                if (mx > 627) mx = 627;
            end
            mdir = dir;
        end
    endtask

    task automatic expect_status();
        st_t s;
        s.x = mx; s.vis = mvis; s.req = mreq; s.fx = mfx;
        sq.push_back(s);
    endtask

    task automatic frame();
        model_tick();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (5) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        expect_status();
    endtask

    task automatic hit_pulse();
        @(negedge Clk) PlayerHit = 1'b1;
        if (mvis == 1) begin
            mvis = 0; mreq = 0; mresp = 90; mrun = 0; mdir = 0;
        end
        @(negedge Clk) PlayerHit = 1'b0;
        expect_status();
    endtask

    task automatic ack_pulse();
        @(negedge Clk) FireAck = 1'b1;
        if (mreq == 1) begin
            mreq = 0; mcool = 20;
        end
        @(negedge Clk) FireAck = 1'b0;
        expect_status();
    endtask

    task automatic async_reset();
        @(negedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        chk("arst_x", int'(PlayerX), 320);
        chk("arst_vis", int'(PlayerVisible), 1);
        chk("arst_req", int'(FireReq), 0);
        chk("arst_fx", int'(FireX), 0);
        model_reset();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        expect_status();
    endtask

    function automatic logic [7:0] pick_key();
        logic [7:0] k;
        case ($urandom_range(0, 5))
            0:       k = 8'h00;
            1:       k = 8'h04;
            2:       k = 8'h07;
            3, 4:    k = 8'h2C;
            default: k = 8'($urandom_range(0, 255));
        endcase
        return k;
    endfunction

    // Status monitor: compares every queued expectation just after the negedge
    initial begin
        st_t s;
        forever begin
            @(negedge Clk);
            #1;
            while (sq.size() > 0) begin
                s = sq.pop_front();
                chk("player_x", int'(PlayerX), s.x);
                chk("visible", int'(PlayerVisible), s.vis);
                chk("fire_req", int'(FireReq), s.req);
                chk("fire_x", int'(FireX), s.fx);
                chk("player_y", int'(PlayerY), 460);
                chk("size", int'(Size), 4);
            end
        end
    end

    // Fire monitor: each rising FireReq must match the next modelled fire
    initial begin
        forever begin
            @(posedge FireReq);
            #1;
            if (fq.size() == 0) chk("fire_unexpected", 1, 0);
            else                chk("fire_latch_x", int'(FireX), fq.pop_front());
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        model_reset();
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        expect_status();
        repeat (5) frame();
        @(negedge Clk);
        chk("idle_x", int'(PlayerX), 320);
        chk("idle_y", int'(PlayerY), 460);
        chk("idle_req", int'(FireReq), 0);
        chk("idle_vis", int'(PlayerVisible), 1);

`ifdef PLAYER_ACCEL_EN
        Keycode0 = 8'h07;
        repeat (20) frame();
        Keycode0 = 8'h00;
        chk("accel_x", int'(PlayerX), 360);
`else
        Keycode0 = 8'h04;
        repeat (110) frame();
        Keycode0 = 8'h00;
        chk("left_x", int'(PlayerX), 100);

        Keycode1 = 8'h2C;
        frame();
        chk("fire_req_100", int'(FireReq), 1);
        chk("fire_x_100", int'(FireX), 100);
        repeat (50) @(negedge Clk);
        chk("req_hold", int'(FireReq), 1);
        ack_pulse();
        chk("req_drop", int'(FireReq), 0);
        n = 0;
        while (FireReq == 1'b0 && n < 40) begin
            frame();
            n++;
        end
        chk("refire_ticks", n, 21);
        ack_pulse();
        Keycode1 = 8'h00;

        Keycode0 = 8'h07;
        repeat (250) frame();
        Keycode0 = 8'h00;
        chk("right_x", int'(PlayerX), 600);
        Keycode1 = 8'h2C;
        frame();
        Keycode1 = 8'h00;
        chk("fire_req_600", int'(FireReq), 1);
        hit_pulse();
        chk("hit_vis", int'(PlayerVisible), 0);
        chk("hit_req", int'(FireReq), 0);
        repeat (45) frame();
        hit_pulse();
        repeat (44) frame();
        chk("still_dead", int'(PlayerVisible), 0);
        frame();
        chk("respawn_x", int'(PlayerX), 320);
        chk("respawn_vis", int'(PlayerVisible), 1);

        Keycode0 = 8'h04;
        Keycode1 = 8'h07;
        repeat (5) frame();
        chk("both_keys_x", int'(PlayerX), 320);
        Keycode1 = 8'h00;
        Keycode0 = 8'h07;
        repeat (200) frame();
        Keycode0 = 8'h00;
        chk("sat_x", int'(PlayerX), 627);
`endif

        for (int i = 0; i < 200; i++) begin
            Keycode0 = pick_key();
            Keycode1 = pick_key();
            frame();
            if ($urandom_range(0, 24) == 0) hit_pulse();
            if ($urandom_range(0, 2) == 0)  ack_pulse();
        end

        // Reset while a fire request may be pending, then during respawn
        Keycode0 = 8'h00;
        Keycode1 = 8'h2C;
        n = 0;
        while (FireReq == 1'b0 && n < 30) begin
            frame();
            n++;
        end
        async_reset();
        Keycode1 = 8'h00;
        repeat (3) frame();
        hit_pulse();
        repeat (10) frame();
        async_reset();
        repeat (3) frame();

        repeat (4) @(negedge Clk);
        chk("fire_queue_empty", fq.size(), 0);
        chk("status_queue_empty", sq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
